dm_port_arbiter: RTL
====================

// Module: dm_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the single-port word data memory.
//  Port 0 is the pipeline M stage; port 1 is a loader/DMA port.
//  Grants at most one access per cycle and drives the DM write/address/data lines.
//  Read data is registered per port and returned one cycle after grant.
// PARAMETERS
//  ADDR_LIMIT  32'h0000_3000  first illegal byte address (3072 words x 4)
//  FIXED_PRIO  0              1: port 0 always wins; 0: round-robin
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  req0_valid   in   1   port 0 request present
//  req0_we      in   1   port 0 write (1) / read (0)
//  req0_addr    in   32  port 0 byte address, bits [1:0] ignored
//  req0_wd      in   32  port 0 write data
//  req0_ready   out  1   port 0 granted this cycle (combinational)
//  req0_rvalid  out  1   port 0 read data valid (registered)
//  req0_rdata   out  32  port 0 read data (registered)
//  req1_*       --   --  identical set for port 1
//  dm_we        out  1   DM write enable
//  dm_addr      out  32  DM byte address {addr[31:2],2'b0}
//  dm_wd        out  32  DM write data
//  dm_rd        in   32  DM combinational read data of dm_addr
// BEHAVIOUR
//  - State: last_grant (1b), rvalid0/1, rdata0/1. No other FSM state.
//  - Reset (sync, while reset=1): last_grant<=1 (port 0 wins first tie), rvalid*<=0,
//    rdata*<=0; readyN=0 and dm_we=0 combinationally while reset is high.
//  - Grant (comb.): one valid -> it wins. Both valid: FIXED_PRIO=1 -> port 0;
//    else port != last_grant. None valid -> no grant, dm_we=0, dm_addr=0, dm_wd=0.
//  - Handshake: transfer occurs in cycle where valid&ready; requester holds
//    valid/we/addr/wd stable until ready. ready never asserted without valid.
//  - last_grant updates at posedge only on a transfer; idle cycles keep it.
//  - Write: dm_we = granted_we & in_range; DM writes at that posedge.
//  - Read: at posedge after a read transfer, rdataN<=in_range?dm_rd:0, rvalidN<=1.
//    rvalidN is a 1-cycle pulse; rdataN holds until next read on that port.
//  - Writes produce no rvalid.
//  - in_range = addr < ADDR_LIMIT (unsigned, full 32b compare). Out-of-range
//    transfers still complete (ready=1) but write suppressed, read returns 0.
//  - Latency: read issued cycle t -> rvalid/rdata at t+1. Back-to-back grants
//    to the same port allowed when the other port is idle (1 access/cycle).
//  - Ordering: write granted at t is visible to a read granted at t+1 (any port).
//  - Reset mid-operation: pending rvalid dropped, grant ptr reset, no DM write
//    in reset cycle; requesters must re-present after reset.
// TESTING
//  1 Reset, both ports read valid continuously -> grants 0,1,0,1...; each rvalid
//    one cycle after its grant.
//  2 Only port 1 valid, 4 reads addr 0,4,8,C -> ready1=1 every cycle, rdata1
//    sequence matches DM contents, ready0=0.
//  3 Port 0 write addr 0x10 data 0xDEADBEEF at t; port 1 read 0x10 at t+1
//    -> rdata1=0xDEADBEEF at t+2.
//  4 Write addr 0x3000 data 0x1 -> ready=1, dm_we=0; read 0x3000 -> rdata=0.
//  5 FIXED_PRIO=1, both valid 3 cycles -> port 0 granted all 3, port 1 stalls.
//  6 Read granted, reset asserted next cycle -> rvalid=0, ready*=0, dm_we=0;
//    after release first tie goes to port 0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter in front of the single-port word data memory.
// One access granted per cycle; read data is registered per port and returned the following cycle.
module dm_port_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wd,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wd,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          r_last_grant;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_pick1;
  logic          w_grant;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wd;
  logic          w_in_range;
  logic          w_rd_xfer0;
  logic          w_rd_xfer1;
  logic [DW-1:0] w_rd_data;

  // Winner select: a tie goes to the port that did not win the last transfer.
  always_comb begin
    w_pick1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_pick1 = FIXED_PRIO ? 1'b0 : !r_last_grant;
    end else begin
      w_pick1 = req1_valid;
    end
  end

  assign w_grant = !reset && (req0_valid || req1_valid);

  // Granted request onto the memory bus; all zero when nothing is granted.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_wd   = '0;
    if (w_grant) begin
      if (w_pick1) begin
        w_sel_we   = req1_we;
        w_sel_addr = req1_addr;
        w_sel_wd   = req1_wd;
      end else begin
        w_sel_we   = req0_we;
        w_sel_addr = req0_addr;
        w_sel_wd   = req0_wd;
      end
    end
  end

  assign w_in_range = (w_sel_addr < ADDR_LIMIT);
  assign w_rd_xfer0 = req0_ready && !req0_we;
  assign w_rd_xfer1 = req1_ready && !req1_we;
  assign w_rd_data  = w_in_range ? dm_rd : '0;

  assign req0_ready  = w_grant && !w_pick1;
  assign req1_ready  = w_grant && w_pick1;
  assign dm_we       = w_grant && w_sel_we && w_in_range;
  assign dm_addr     = {w_sel_addr[AW-1:2], 2'b00};
  assign dm_wd       = w_sel_wd;
  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

  // Grant pointer moves only on a transfer; read data captured one cycle after grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_pick1;
      end
      r_rvalid0 <= w_rd_xfer0;
      r_rvalid1 <= w_rd_xfer1;
      if (w_rd_xfer0) begin
        r_rdata0 <= w_rd_data;
      end
      if (w_rd_xfer1) begin
        r_rdata1 <= w_rd_data;
      end
    end
  end

endmodule
